// File: rtl/res_serie_v1_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state
// encoding and the state type used by the top level.
package res_serie_v1_pkg;

  // Controller state encoding (2 bits, legacy-compatible constants)
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_RESTA = 2'b01;
  localparam state_t ST_FIN   = 2'b10;

endpackage

// File: rtl/res1_v1.sv
// One-bit full subtractor: diff = x - y - bi, bor set on underflow.
module res1_v1 (
  output logic diff,
  output logic bor,
  input  logic x,
  input  logic y,
  input  logic bi
);

  // Pure combinational cell; no state.
  always_comb begin
    diff = x ^ y ^ bi;
    bor  = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/res_serie_v1.sv
// Bit-serial W-bit subtractor, D = A - B - b_in, LSB first, one bit per
// clock over a start/done handshake. A single full-subtractor cell works on
// the low bits of two right-shifting operand registers, the borrow is carried
// between cycles in a flip-flop and the difference bits are shifted in from
// the MSB side of a result register.
module res_serie_v1
  import res_serie_v1_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         b_out,
  output logic         ovf
);

  state_t        state;
  logic [W-1:0]  sa;        // minuend, shifted right each bit
  logic [W-1:0]  sb;        // subtrahend, shifted right each bit
  logic [W-1:0]  sr;        // partial result, filled from the MSB side
  logic          borrow;    // borrow into the bit being processed
  logic          msb_bi;    // borrow into the MSB, kept for ovf
  logic [CW-1:0] cnt;       // index of the bit being processed
  logic          diff;
  logic          bor;
  logic          accept;
  logic          last_bit;

  // The single arithmetic cell of the datapath
  res1_v1 u_cell (
    .diff (diff),
    .bor  (bor),
    .x    (sa[0]),
    .y    (sb[0]),
    .bi   (borrow)
  );

  // Handshake flags decode straight from the registered state
  always_comb begin
    busy     = (state == ST_RESTA);
    done     = (state == ST_FIN);
    accept   = start && ((state == ST_IDLE) || (state == ST_FIN));
    last_bit = (cnt == CW'(W - 1));
  end

  // Controller and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      borrow <= 1'b0;
      msb_bi <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every term on the right is the
      // pre-edge value; msb_bi latched at bit W-2 is read one edge later.
      case (state)
        ST_IDLE, ST_FIN: begin
          if (accept) begin
            sa     <= a;
            sb     <= b;
            borrow <= b_in;
            cnt    <= '0;
            state  <= ST_RESTA;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_RESTA: begin
          sr     <= {diff, sr[W-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bor;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 2)) begin
            msb_bi <= bor;
          end
          if (last_bit) begin
            d     <= {diff, sr[W-1:1]};
            b_out <= bor;
            ovf   <= msb_bi ^ bor;
            state <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_serie_v1.sv
// Self-checking bench for res_serie_v1: directed cases from the test plan
// plus randomized operations, compared against an arithmetic reference.
module tb_res_serie_v1;

  localparam int W  = 4;
  localparam int CW = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         ovf;

  int tests;
  int fails;

  // Last result the DUT should be holding on its outputs
  logic [W-1:0] held_d;
  logic         held_bo;
  logic         held_ovf;

  res_serie_v1 #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, unsigned for d/b_out, signed range
  // test for overflow.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra,
                                           input logic [W-1:0] rb,
                                           input logic rbin);
    int ua, ub, sa, sb, ur, sr;
    logic [W-1:0] rd;
    logic rbo, rov;
    ua = int'(ra);
    ub = int'(rb);
    sa = ra[W-1] ? ua - (1 << W) : ua;
    sb = rb[W-1] ? ub - (1 << W) : ub;
    ur = ua - ub - int'(rbin);
    sr = sa - sb - int'(rbin);
    rbo = (ur < 0);
    rd  = W'(ur + (rbo ? (1 << W) : 0));
    rov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return {rov, rbo, rd};
  endfunction

  // Present an operation; called at a negedge, accepted at the next posedge
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tbin);
    a     = ta;
    b     = tb;
    b_in  = tbin;
    start = 1'b1;
  endtask

  // Follow one operation from its accepting edge to done and check it.
  // scramble: change operands while busy; poke: toggle start during RESTA;
  // hold: leave start high throughout.
  task automatic run_op(input string name, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tbin,
                        input bit scramble, input bit poke, input bit hold);
    logic [W+1:0] exp;
    exp = ref_sub(ta, tb, tbin);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    if (scramble) begin
      a    = W'($urandom);
      b    = W'($urandom);
      b_in = 1'($urandom);
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s busy/done cycle %0d: got busy=%b done=%b, want busy=1 done=0",
                 name, i, busy, done);
      end
      tests++;
      if (d !== held_d || b_out !== held_bo || ovf !== held_ovf) begin
        fails++;
        $display("FAIL %s hold cycle %0d: got d=%b b_out=%b ovf=%b, want d=%b b_out=%b ovf=%b",
                 name, i, d, b_out, ovf, held_d, held_bo, held_ovf);
      end
      if (poke) start = (i % 2 == 0);
      if (scramble) begin
        a    = W'($urandom);
        b    = W'($urandom);
        b_in = 1'($urandom);
      end
    end
    if (poke) start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done: got busy=%b done=%b, want busy=0 done=1", name, busy, done);
    end
    tests++;
    if (d !== exp[W-1:0] || b_out !== exp[W] || ovf !== exp[W+1]) begin
      fails++;
      $display("FAIL %s result: got d=%b b_out=%b ovf=%b, want d=%b b_out=%b ovf=%b",
               name, d, b_out, ovf, exp[W-1:0], exp[W], exp[W+1]);
    end
    held_d   = exp[W-1:0];
    held_bo  = exp[W];
    held_ovf = exp[W+1];
  endtask

  // Drop start and let the FIN cycle fall back to IDLE
  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    held_d = '0; held_bo = 1'b0; held_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, d, b_out, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b d=%b b_out=%b ovf=%b, want all 0",
               busy, done, d, b_out, ovf);
    end
  endtask

  task automatic test_directed();
    issue(4'b0000, 4'b0000, 1'b1);
    run_op("borrow_only", 4'b0000, 4'b0000, 1'b1, 0, 0, 0);
    idle_cycle();
    issue(4'b1111, 4'b0001, 1'b0);
    run_op("simple_sub", 4'b1111, 4'b0001, 1'b0, 0, 0, 0);
    idle_cycle();
    issue(4'b0000, 4'b1111, 1'b1);
    run_op("underflow", 4'b0000, 4'b1111, 1'b1, 0, 0, 0);
    idle_cycle();
    issue(4'b0101, 4'b1010, 1'b0);
    run_op("ovf_pos", 4'b0101, 4'b1010, 1'b0, 0, 0, 0);
    idle_cycle();
    issue(4'b1000, 4'b0001, 1'b0);
    run_op("ovf_neg", 4'b1000, 4'b0001, 1'b0, 0, 0, 0);
    idle_cycle();
    issue(4'b0110, 4'b0110, 1'b1);
    run_op("equal_bin", 4'b0110, 4'b0110, 1'b1, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_handshake();
    issue(4'b1001, 4'b0011, 1'b0);
    run_op("scramble", 4'b1001, 4'b0011, 1'b0, 1, 0, 0);
    idle_cycle();
    issue(4'b0111, 4'b1100, 1'b1);
    run_op("poke_start", 4'b0111, 4'b1100, 1'b1, 0, 1, 0);
    idle_cycle();
    // start held high: done every W+1 cycles, busy low only in FIN
    issue(4'b1100, 4'b0101, 1'b0);
    run_op("hold_0", 4'b1100, 4'b0101, 1'b0, 0, 0, 1);
    issue(4'b0010, 4'b0111, 1'b1);
    run_op("hold_1", 4'b0010, 4'b0111, 1'b1, 0, 0, 1);
    issue(4'b1111, 4'b1110, 1'b0);
    run_op("hold_2", 4'b1111, 4'b1110, 1'b0, 0, 0, 1);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    issue(4'b1010, 4'b0110, 1'b0);
    run_op("b2b_first", 4'b1010, 4'b0110, 1'b0, 0, 0, 0);
    issue(4'b0011, 4'b0001, 1'b0);
    run_op("b2b_second", 4'b0011, 4'b0001, 1'b0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    issue(4'b0100, 4'b0001, 1'b1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, d, b_out, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b d=%b b_out=%b ovf=%b, want all 0",
               busy, done, d, b_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held_d = '0; held_bo = 1'b0; held_ovf = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || d !== '0) begin
        fails++;
        $display("FAIL reset_no_done cycle %0d: got busy=%b done=%b d=%b, want 0 0 0000",
                 i, busy, done, d);
      end
    end
    issue(4'b1101, 4'b0100, 1'b0);
    run_op("after_reset", 4'b1101, 4'b0100, 1'b0, 0, 0, 0);
    idle_cycle();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rbin;
    bit chain;
    chain = 0;
    for (int n = 0; n < 40; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      issue(ra, rb, rbin);
      run_op("random", ra, rb, rbin, 1'($urandom), 0, 0);
      chain = 1'($urandom);
      if (!chain) idle_cycle();
    end
    if (chain) idle_cycle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
